mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 37 +++
 rtl/mem_lsu_align.sv | 41 ++++
 rtl/mem_lsu.sv | 126 ++++++++++++
 tb/tb_mem_lsu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states
// and the lane/alignment helpers used by the top and the align datapath.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RMW  = 2'b10
  } state_t;

  // Size 2'b11 has bit 1 set and therefore decodes as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  // Lane actually used: low address bits beyond the access size are dropped.
  function automatic logic [1:0] lane_of(input logic [1:0] addr_lo, input logic [1:0] size);
    logic [1:0] lane;
    lane = 2'b00;
    if (size == SZ_BYTE)      lane = addr_lo;
    else if (size == SZ_HALF) lane = {addr_lo[1], 1'b0};
    return lane;
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF)  bad = addr_lo[0];
    else if (is_word(size)) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane datapath: extracts and extends load data from a RAM word,
// and merges byte/half store data into a RAM word for read-modify-write.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] ram_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] shifted;
  logic [31:0] wrep;
  logic [3:0]  byte_en;

  assign shifted = ram_data >> {lane, 3'b000};

  always_comb begin
    load_data = ram_data;
    wrep      = wdata;
    byte_en   = 4'b1111;
    if (size == SZ_BYTE) begin
      load_data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      wrep      = {4{wdata[7:0]}};
      byte_en   = 4'b0001 << lane;
    end else if (size == SZ_HALF) begin
      load_data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      wrep      = {2{wdata[15:0]}};
      byte_en   = 4'b0011 << lane;
    end
  end

  // Replicated store data means each enabled lane already sees its own bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merge_data[gi*8 +: 8] = byte_en[gi] ? wrep[gi*8 +: 8] : ram_data[gi*8 +: 8];
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a write-first, 1-cycle-read RAM port. Define
// MEM_LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses with o_rsp_err.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter  int DEPTH = 2**16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_data,
  output logic          o_ram_we,
  input  logic [31:0]   i_ram_data
);

  state_t        state_reg;
  logic [AW-1:0] addr_reg;
  logic [1:0]    lane_reg;
  logic [1:0]    size_reg;
  logic          zext_reg;
  logic [31:0]   wdata_reg;
  logic          rsp_valid_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          rsp_err_reg;

  logic          accept;
  logic          bad_align;
  logic          word_store_go;
  logic [31:0]   load_data;
  logic [31:0]   merge_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_req_addr[31:AW+2];

  assign accept = i_req_valid && (state_reg == IDLE);

`ifdef MEM_LSU_MISALIGN_CHECK_EN
  assign bad_align = misaligned(i_req_addr[1:0], i_req_size);
`else
  assign bad_align = 1'b0;
`endif

  assign word_store_go = accept && i_req_we && is_word(i_req_size) && !bad_align;

  // Gated by reset so an accept-time store cannot leak through while held in reset.
  assign o_ram_we    = i_rst_n && (word_store_go || (state_reg == RMW));
  assign o_ram_data  = (state_reg == RMW) ? merge_data : i_req_wdata;
  assign o_ram_addr  = (state_reg == IDLE) ? i_req_addr[AW+1:2] : addr_reg;
  assign o_req_ready = (state_reg == IDLE);
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_rsp_err   = rsp_err_reg;

  mem_lsu_align u_align (
    .ram_data   (i_ram_data),
    .lane       (lane_reg),
    .size       (size_reg),
    .zero_ext   (zext_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      lane_reg      <= '0;
      size_reg      <= '0;
      zext_reg      <= 1'b0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= i_req_addr[AW+1:2];
            lane_reg  <= lane_of(i_req_addr[1:0], i_req_size);
            size_reg  <= i_req_size;
            zext_reg  <= i_req_unsigned;
            wdata_reg <= i_req_wdata;
            if (bad_align) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else if (!i_req_we) begin
              state_reg <= RD;
            end else if (is_word(i_req_size)) begin
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              state_reg <= RMW;
            end
          end
        end
        RD: begin
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= load_data;
          state_reg     <= IDLE;
        end
        RMW: begin
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= '0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a write-first, registered-read RAM model.
// Expectations for the misaligned word store follow MEM_LSU_MISALIGN_CHECK_EN.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TB_DEPTH = 64;
  localparam int TB_AW    = $clog2(TB_DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [TB_AW-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic             ram_we;
  logic [31:0]      ram_rdata;

  logic [31:0] ram_mem [TB_DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DEPTH(TB_DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_ram_addr     (ram_addr),
    .o_ram_data     (ram_wdata),
    .o_ram_we       (ram_we),
    .i_ram_data     (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_we ? ram_wdata : ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One request: checks ready and accept-time write, then response latency/data/err.
  task automatic txn(input string name, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic [31:0] exp_rdata,
                     input logic exp_err, input logic exp_we);
    int lat;
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    #1;
    check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    check({name, ".we_at_accept"}, {31'd0, ram_we}, {31'd0, exp_we});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, lat, exp_lat);
    if (rsp_valid) begin
      check({name, ".rdata"}, rsp_rdata, exp_rdata);
      check({name, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    end
    $display("txn %-12s we=%0d size=%0d addr=0x%08h lat=%0d rdata=0x%08h err=%0d",
             name, we, size, addr, lat, rsp_rdata, rsp_err);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    #1;
    check("rst.ram_we", {31'd0, ram_we}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.err", {31'd0, rsp_err}, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;

    txn("st_w", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, 1'b1);
    check("st_w.mem", ram_mem[4], 32'hDEAD_BEEF);
    txn("ld_w", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);

    txn("st_w_pre", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 1, 32'h0, 1'b0, 1'b1);
    txn("st_b", 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0000_00AA, 2, 32'h0, 1'b0, 1'b0);
    check("st_b.mem", ram_mem[4], 32'hAA22_3344);
    txn("ld_b_s", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 1'b0);
    txn("ld_b_u", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 2, 32'h0000_00AA, 1'b0, 1'b0);

    txn("st_h", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_8001, 2, 32'h0, 1'b0, 1'b0);
    check("st_h.mem", ram_mem[4], 32'h8001_3344);
    txn("ld_h_s", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1'b0);
    txn("ld_h_u", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 2, 32'h0000_8001, 1'b0, 1'b0);
    txn("ld_h_lo", 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 2, 32'h0000_3344, 1'b0, 1'b0);

    // Size 2'b11 behaves as a word; byte/half from a positive word sign-extend with zeros.
    txn("st_sz3", 1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678, 1, 32'h0, 1'b0, 1'b1);
    txn("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
    txn("ld_b1", 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 2, 32'h0000_0056, 1'b0, 1'b0);

    // 0x124 wraps modulo 4*DEPTH = 0x100 onto word 9.
    txn("st_wrap", 1'b1, SZ_WORD, 1'b0, 32'h124, 32'hA5A5_0F0F, 1, 32'h0, 1'b0, 1'b1);
    check("st_wrap.mem", ram_mem[9], 32'hA5A5_0F0F);

    // Back-to-back loads: second one is accepted on the first one's response cycle.
    @(negedge clk);
    drive(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    #1;
    check("b2b.ready_rd", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b.rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b.rsp1_rdata", rsp_rdata, 32'h8001_3344);
    check("b2b.ready_rsp", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b.rsp2_gap", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("b2b.rsp2_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b.rsp2_rdata", rsp_rdata, 32'h1234_5678);
    $display("txn b2b_loads   rdata2=0x%08h", rsp_rdata);

    // Reset during RMW: the merge write must not reach the RAM and no response appears.
    txn("st_w28", 1'b1, SZ_WORD, 1'b0, 32'h28, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("ld_w24", 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, 2, 32'hA5A5_0F0F, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, SZ_BYTE, 1'b0, 32'h28, 32'h0000_0055);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rmw.we_before_rst", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw.we_in_rst", {31'd0, ram_we}, 32'd0);
    check("rmw.rdata_in_rst", rsp_rdata, 32'd0);
    @(negedge clk);
    check("rmw.no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rmw.mem", ram_mem[10], 32'd0);
    rst_n = 1'b1;
    #1;
    check("rmw.ready_after", {31'd0, req_ready}, 32'd1);
    $display("txn rmw_reset   mem[10]=0x%08h", ram_mem[10]);

`ifdef MEM_LSU_MISALIGN_CHECK_EN
    txn("st_mis", 1'b1, SZ_WORD, 1'b0, 32'h11, 32'hCAFE_F00D, 1, 32'h0, 1'b1, 1'b0);
    check("st_mis.mem", ram_mem[4], 32'h8001_3344);
`else
    txn("st_mis", 1'b1, SZ_WORD, 1'b0, 32'h11, 32'hCAFE_F00D, 1, 32'h0, 1'b0, 1'b1);
    check("st_mis.mem", ram_mem[4], 32'hCAFE_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
